operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the clock, and rst resets the block at a rising clk edge.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  a decoded instruction is presented this cycle.
REQ-005 stall  input  1  hold the output latch contents.
REQ-006 flush  input  1  kill the instruction entering the latch.
REQ-007 rs_sel  input  3  register number for operand A.
REQ-008 rt_sel  input  3  register number for operand B.
REQ-009 imm  input  16  immediate value for operand B.
REQ-010 use_imm  input  1  1 selects imm as B; 0 selects register rt.
REQ-011 op_in, cin_in, invA_in, invB_in, sign_in  input  3/1/1/1/1  ALU control fields from decode.
REQ-012 wr_en  input  1  register write from writeback.
REQ-013 wr_sel  input  3  register number for the writeback write.
REQ-014 wr_data  input  16  writeback data.
REQ-015 A, B  output  16 each  latched ALU operands.
REQ-016 op, cin, invA, invB, sign  output  3/1/1/1/1  latched ALU control fields.
REQ-017 out_valid  output  1  the latch holds a live instruction.

Function
REQ-018 The block SHALL contain an 8 x 16-bit register file R0-R7, and every register SHALL be writable.
REQ-019 On a rising edge with wr_en=1, R[wr_sel] SHALL take wr_data; a write SHALL occur regardless of stall or flush.
REQ-020 Read SHALL bypass: when wr_en=1 and wr_sel equals the register being read in the same cycle, the value seen SHALL be wr_data rather than the old register contents.
REQ-021 Capture with stall=0 and flush=0: A, B and control SHALL load, with A = bypassed R[rs_sel], B = use_imm ? imm : bypassed R[rt_sel], and out_valid = in_valid.
REQ-022 The latency from the decode inputs to the outputs SHALL be exactly one cycle.
REQ-023 The block SHALL also latch rs_sel, rt_sel and use_imm as internal tags.
REQ-024 With stall=1 and flush=0, the latch contents, the control outputs and out_valid SHALL hold.
REQ-025 Exception to REQ-024: if wr_en=1 and wr_sel equals the latched rs tag, A SHALL take wr_data (stall refresh).
REQ-026 Likewise under stall, if wr_en=1, wr_sel equals the latched rt tag and the latched use_imm=0, B SHALL take wr_data.
REQ-027 Flush SHALL take priority over stall: when flush=1, A, B, op, cin, invA, invB, sign and out_valid SHALL all become 0 on the next edge.
REQ-028 Two-state FSM for the latch:
- EMPTY (out_valid=0) -> FULL when in_valid=1, stall=0 and flush=0.
- FULL -> EMPTY when flush=1, or when stall=0 and in_valid=0.
- FULL -> FULL when stalled without flush, or on a new capture.
REQ-029 When out_valid=0, the operand values SHALL still follow REQ-021 (don't-care to the consumer) but SHALL never be X after reset.
REQ-030 rs_sel may equal rt_sel, and both SHALL receive the same bypassed value.
REQ-031 A write to a register that is neither latched tag SHALL NOT disturb the latch under stall.

Reset
REQ-032 While rst=1 at a clock edge, R0-R7, A, B, op, cin, invA, invB, sign, out_valid and all tags SHALL become 0.
REQ-033 rst SHALL override wr_en, stall and flush: a write presented in the reset cycle SHALL be discarded.
REQ-034 On the first edge after rst deasserts, the block SHALL capture normally per REQ-021.

Verification
REQ-035 Scenario, reset then read: rst=1 one cycle, then read rs=3, rt=5 with in_valid=1 -> A=0x0000, B=0x0000, out_valid=1 next cycle.
REQ-036 Scenario, write-then-read bypass: in one cycle, wr_en=1, wr_sel=2, wr_data=0xBEEF, rs_sel=2, rt_sel=2 -> next cycle A=0xBEEF, B=0xBEEF; on the following cycle R2 reads back 0xBEEF.
REQ-037 Scenario, stall refresh: latch rs=4 (A=0x0011), then stall=1 with wr_en=1, wr_sel=4, wr_data=0x1234 -> A=0x1234 and out_valid held at 1.
- Same stall with wr_sel=6 -> A stays 0x0011.
REQ-038 Scenario, flush over stall: out_valid=1, then stall=1 and flush=1 together -> next cycle out_valid=0 and A=B=op=0.
REQ-039 Scenario, immediate select: use_imm=1, imm=0xFFF0, rt_sel=1 with R1=0x7777 -> B=0xFFF0.
- Then stall with wr_sel=1 -> B stays 0xFFF0.
REQ-040 Scenario, reset mid-operation: out_valid=1 with rst=1, wr_en=1, wr_sel=0, wr_data=0xAAAA -> all outputs 0 and R0 reads 0x0000 afterwards.

Source files
------------

// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_stage
// Purpose  : 8x16 register file with write bypass feeding a one-cycle operand
//            latch (A/B + ALU control) with stall refresh and flush.
// Revision : 1.0 - initial release
// ============================================================================
module operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  rs_sel,
  input  logic [2:0]  rt_sel,
  input  logic [15:0] imm,
  input  logic        use_imm,
  input  logic [2:0]  op_in,
  input  logic        cin_in,
  input  logic        invA_in,
  input  logic        invB_in,
  input  logic        sign_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [15:0] wr_data,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [2:0]  op,
  output logic        cin,
  output logic        invA,
  output logic        invB,
  output logic        sign,
  output logic        out_valid
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_regs [8];
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [2:0]  r_op;
  logic        r_cin;
  logic        r_inva;
  logic        r_invb;
  logic        r_sign;
  logic [2:0]  r_rs_tag;
  logic [2:0]  r_rt_tag;
  logic        r_use_imm_tag;

  logic [15:0] w_rd_a;
  logic [15:0] w_rd_b;
  logic        w_refresh_a;
  logic        w_refresh_b;

  // Writeback data forwarded to readers of the register being written
  assign w_rd_a = (wr_en && (wr_sel == rs_sel)) ? wr_data : r_regs[rs_sel];
  assign w_rd_b = (wr_en && (wr_sel == rt_sel)) ? wr_data : r_regs[rt_sel];

  assign w_refresh_a = wr_en && (wr_sel == r_rs_tag);
  assign w_refresh_b = wr_en && (wr_sel == r_rt_tag) && !r_use_imm_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 16'h0000;
      end
    end else if (wr_en) begin
      r_regs[wr_sel] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_EMPTY;
    end else if (!stall) begin
      w_state_next = in_valid ? S_FULL : S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_a           <= 16'h0000;
      r_b           <= 16'h0000;
      r_op          <= 3'd0;
      r_cin         <= 1'b0;
      r_inva        <= 1'b0;
      r_invb        <= 1'b0;
      r_sign        <= 1'b0;
      r_rs_tag      <= 3'd0;
      r_rt_tag      <= 3'd0;
      r_use_imm_tag <= 1'b0;
    end else if (stall) begin
      // Held operands track writes to their source registers
      if (w_refresh_a) r_a <= wr_data;
      if (w_refresh_b) r_b <= wr_data;
    end else begin
      r_a           <= w_rd_a;
      r_b           <= use_imm ? imm : w_rd_b;
      r_op          <= op_in;
      r_cin         <= cin_in;
      r_inva        <= invA_in;
      r_invb        <= invB_in;
      r_sign        <= sign_in;
      r_rs_tag      <= rs_sel;
      r_rt_tag      <= rt_sel;
      r_use_imm_tag <= use_imm;
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign op        = r_op;
  assign cin       = r_cin;
  assign invA      = r_inva;
  assign invB      = r_invb;
  assign sign      = r_sign;
  assign out_valid = (r_state == S_FULL);

endmodule
`default_nettype wire

// File: tb/tb_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_stage
// Purpose  : Directed self-checking bench for operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush, use_imm, wr_en;
  logic [2:0]  rs_sel, rt_sel, wr_sel, op_in;
  logic        cin_in, invA_in, invB_in, sign_in;
  logic [15:0] imm, wr_data;
  logic [15:0] A, B;
  logic [2:0]  op;
  logic        cin, invA, invB, sign, out_valid;

  int checks   = 0;
  int failures = 0;

  operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .imm(imm), .use_imm(use_imm),
    .op_in(op_in), .cin_in(cin_in), .invA_in(invA_in), .invB_in(invB_in),
    .sign_in(sign_in), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .A(A), .B(B), .op(op), .cin(cin), .invA(invA), .invB(invB), .sign(sign),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; stall = 0; flush = 0; use_imm = 0; wr_en = 0;
    rs_sel = 0; rt_sel = 0; wr_sel = 0; op_in = 0;
    cin_in = 0; invA_in = 0; invB_in = 0; sign_in = 0;
    imm = 0; wr_data = 0;
  endtask

  task automatic write_reg(input logic [2:0] sel, input logic [15:0] data);
    idle_inputs();
    wr_en = 1; wr_sel = sel; wr_data = data;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    // Reset with a write presented: write must be discarded
    wr_en = 1; wr_sel = 3; wr_data = 16'h5555; in_valid = 1;
    tick();
    check_val("rst_A", A, 16'h0000);
    check_val("rst_B", B, 16'h0000);
    check_val("rst_op", {13'd0, op}, 16'h0000);
    check_val("rst_valid", {15'd0, out_valid}, 16'h0000);
    rst = 0;

    // Reset then read rs=3, rt=5
    idle_inputs();
    in_valid = 1; rs_sel = 3; rt_sel = 5;
    tick();
    check_val("read0_A", A, 16'h0000);
    check_val("read0_B", B, 16'h0000);
    check_val("read0_valid", {15'd0, out_valid}, 16'h0001);

    // Write-then-read bypass on R2
    idle_inputs();
    in_valid = 1; wr_en = 1; wr_sel = 2; wr_data = 16'hBEEF;
    rs_sel = 2; rt_sel = 2; op_in = 3'd5; cin_in = 1;
    tick();
    check_val("byp_A", A, 16'hBEEF);
    check_val("byp_B", B, 16'hBEEF);
    check_val("byp_op", {13'd0, op}, 16'h0005);
    check_val("byp_cin", {15'd0, cin}, 16'h0001);
    idle_inputs();
    in_valid = 1; rs_sel = 2; rt_sel = 0;
    tick();
    check_val("r2_readback", A, 16'hBEEF);
    check_val("r0_readback", B, 16'h0000);

    // Empty capture
    write_reg(4, 16'h0011);
    check_val("empty_valid", {15'd0, out_valid}, 16'h0000);

    // Stall refresh on R4
    idle_inputs();
    in_valid = 1; rs_sel = 4; rt_sel = 4; op_in = 3'd3;
    tick();
    check_val("lat4_A", A, 16'h0011);
    idle_inputs();
    stall = 1; wr_en = 1; wr_sel = 6; wr_data = 16'h9999;
    tick();
    check_val("stall_other_A", A, 16'h0011);
    check_val("stall_other_B", B, 16'h0011);
    check_val("stall_op_hold", {13'd0, op}, 16'h0003);
    idle_inputs();
    stall = 1; wr_en = 1; wr_sel = 4; wr_data = 16'h1234;
    tick();
    check_val("stall_ref_A", A, 16'h1234);
    check_val("stall_ref_B", B, 16'h1234);
    check_val("stall_valid", {15'd0, out_valid}, 16'h0001);

    // Flush takes priority over stall
    idle_inputs();
    stall = 1; flush = 1;
    tick();
    check_val("flush_valid", {15'd0, out_valid}, 16'h0000);
    check_val("flush_A", A, 16'h0000);
    check_val("flush_B", B, 16'h0000);
    check_val("flush_op", {13'd0, op}, 16'h0000);

    // Immediate select, then stall write to rt must not touch B
    write_reg(1, 16'h7777);
    idle_inputs();
    in_valid = 1; use_imm = 1; imm = 16'hFFF0; rs_sel = 1; rt_sel = 1;
    invA_in = 1; sign_in = 1;
    tick();
    check_val("imm_A", A, 16'h7777);
    check_val("imm_B", B, 16'hFFF0);
    check_val("imm_ctl", {12'd0, cin, invA, invB, sign}, 16'h0005);
    idle_inputs();
    stall = 1; wr_en = 1; wr_sel = 1; wr_data = 16'h2222;
    tick();
    check_val("imm_stall_B", B, 16'hFFF0);
    check_val("imm_stall_A", A, 16'h2222);

    // Writes during stall land in the file; R7 writable
    write_reg(7, 16'h8001);
    idle_inputs();
    in_valid = 1; rs_sel = 6; rt_sel = 7;
    tick();
    check_val("r6_readback", A, 16'h9999);
    check_val("r7_readback", B, 16'h8001);

    // Reset mid-operation with a write to R0
    idle_inputs();
    rst = 1; wr_en = 1; wr_sel = 0; wr_data = 16'hAAAA; in_valid = 1; stall = 1;
    tick();
    check_val("rst2_A", A, 16'h0000);
    check_val("rst2_B", B, 16'h0000);
    check_val("rst2_valid", {15'd0, out_valid}, 16'h0000);
    rst = 0;
    idle_inputs();
    in_valid = 1; rs_sel = 0; rt_sel = 2;
    tick();
    check_val("rst2_r0", A, 16'h0000);
    check_val("rst2_r2", B, 16'h0000);
    check_val("rst2_cap_valid", {15'd0, out_valid}, 16'h0001);

    // Capture with in_valid=0 empties the latch
    idle_inputs();
    tick();
    check_val("drain_valid", {15'd0, out_valid}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
